// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register. Owns the PC and
//   keeps at most one request outstanding to a variable-latency instruction
//   memory. A one-entry skid buffer catches a response that arrives while
//   decode is stalled. Branch/jump redirects squash everything younger.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   stall                hazard stall: IF/ID holds its live instruction
//   redirect/redirect_pc taken branch/jump target (word-aligned)
//   imem_req/imem_addr   fetch request; accepted when imem_ready is high
//   imem_rvalid/rdata    fetch response, >=1 cycle after acceptance
//   D_valid/D_instr/D_pc IF/ID register (D_instr = 0 when not valid)
//   D_pc4                D_pc + 4, combinational, wraps mod 2^32
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        D_valid,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // free to issue
    WAIT  = 2'd1,  // one request outstanding, response wanted
    DROP  = 2'd2   // one request outstanding, response squashed
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        buf_valid;
  ifid_t       buf_q;

  logic        accept;    // request handshake this cycle
  logic        resp;      // response that must be kept (WAIT only)
  logic        can_load;  // IF/ID may take a new entry this cycle
  ifid_t       resp_ent;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) state <= FETCH;
    else         state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and request outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = pc;

    case (state)
      FETCH: begin
        // A full buffer means decode is still backed up; issuing now could
        // produce a second response with nowhere to go.
        imem_req = !buf_valid && !redirect;
        if (imem_req && imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) state_nxt = FETCH;
      end
      DROP: begin
        if (imem_rvalid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    // A redirect while a request is in flight must swallow its response.
    // If the response lands in the same cycle it is simply discarded here.
    // In DROP the in-flight request is already marked for discard, so the
    // normal DROP transition above stands.
    if (redirect) begin
      case (state)
        WAIT:    state_nxt = imem_rvalid ? FETCH : DROP;
        DROP:    state_nxt = imem_rvalid ? FETCH : DROP;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // Responses are only meaningful in WAIT; anything seen in FETCH (e.g. a
  // stray beat right after reset) or DROP is ignored.
  assign accept   = imem_req && imem_ready;
  assign resp     = (state == WAIT) && imem_rvalid;
  assign can_load = !D_valid || !stall;
  assign resp_ent = '{instr: imem_rdata, pc: req_pc};

  assign D_pc4 = D_pc + 32'd4;

  // ---------------------------------------------------------------------------
  // PC, skid buffer and IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc        <= RESET_PC;
      req_pc    <= '0;
      buf_valid <= 1'b0;
      buf_q     <= '0;
      D_valid   <= 1'b0;
      D_instr   <= '0;
      D_pc      <= '0;
    end else if (redirect) begin
      pc        <= redirect_pc;
      buf_valid <= 1'b0;
      D_valid   <= 1'b0;
      D_instr   <= '0;
    end else begin
      if (accept) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end

      if (can_load) begin
        if (buf_valid) begin
          // Older buffered entry goes first to preserve program order; a
          // response arriving at the same time takes its place.
          D_valid <= 1'b1;
          D_instr <= buf_q.instr;
          D_pc    <= buf_q.pc;
          if (resp) buf_q     <= resp_ent;
          else      buf_valid <= 1'b0;
        end else if (resp) begin
          D_valid <= 1'b1;
          D_instr <= resp_ent.instr;
          D_pc    <= resp_ent.pc;
        end else begin
          // Entry consumed (or slot already empty) and nothing to replace it.
          D_valid <= 1'b0;
          D_instr <= '0;
        end
      end else if (resp) begin
        // Decode stalled on a live instruction: park the response.
        buf_valid <= 1'b1;
        buf_q     <= resp_ent;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed, cycle-by-cycle stimulus for fetch_stage with RESET_PC=0x3000.
//   The bench plays the instruction memory by hand; each instruction word is
//   the fetch address XOR a fixed pattern so D_instr can be predicted from
//   D_pc.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        D_valid;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc4;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .D_valid     (D_valid),
    .D_instr     (D_instr),
    .D_pc        (D_pc),
    .D_pc4       (D_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply inputs for the coming cycle, then let combinational outputs settle.
  task automatic drive(input logic stl, input logic rdr, input logic [31:0] rpc,
                       input logic rdy, input logic rv, input logic [31:0] rdat);
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rdat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    tick();
    tick();
    resetn = 1'b1;

    // ---- reset state ----
    drive(0, 0, 0, 1, 0, 0);
    chk("rst_dvalid", {31'd0, D_valid}, 32'd0);
    chk("rst_dinstr", D_instr, 32'd0);
    chk("rst_dpc",    D_pc,    32'd0);
    chk("rst_req",    {31'd0, imem_req}, 32'd1);
    chk("rst_addr",   imem_addr, RPC);
    tick();                                     // 3000 accepted

    // ---- k=1 streaming ----
    drive(0, 0, 0, 1, 1, ins(32'h3000));
    chk("c1_req_wait", {31'd0, imem_req}, 32'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("c2_dvalid", {31'd0, D_valid}, 32'd1);
    chk("c2_dpc",    D_pc,    32'h3000);
    chk("c2_dinstr", D_instr, ins(32'h3000));
    chk("c2_dpc4",   D_pc4,   32'h3004);
    chk("c2_addr",   imem_addr, 32'h3004);
    tick();                                     // 3004 accepted
    drive(0, 0, 0, 1, 1, ins(32'h3004));
    chk("c3_dvalid_gap", {31'd0, D_valid}, 32'd0);
    chk("c3_dinstr_nop", D_instr, 32'd0);
    tick();

    // ---- stall with live D, response goes to buffer ----
    drive(1, 0, 0, 1, 0, 0);
    chk("c4_dpc",  D_pc, 32'h3004);
    chk("c4_addr", imem_addr, 32'h3008);
    chk("c4_req",  {31'd0, imem_req}, 32'd1);
    tick();                                     // 3008 accepted, D held
    drive(1, 0, 0, 1, 1, ins(32'h3008));
    chk("c5_hold_dpc", D_pc, 32'h3004);
    chk("c5_hold_dv",  {31'd0, D_valid}, 32'd1);
    tick();                                     // 3008 -> buffer
    drive(1, 0, 0, 1, 0, 0);
    chk("c6_hold_dpc",  D_pc, 32'h3004);
    chk("c6_hold_ins",  D_instr, ins(32'h3004));
    chk("c6_req_block", {31'd0, imem_req}, 32'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0);                    // release
    chk("c7_req_block", {31'd0, imem_req}, 32'd0);
    chk("c7_dpc",       D_pc, 32'h3004);
    tick();                                     // buffer -> D
    drive(0, 0, 0, 1, 0, 0);
    chk("c8_dvalid", {31'd0, D_valid}, 32'd1);
    chk("c8_dpc",    D_pc, 32'h3008);
    chk("c8_dinstr", D_instr, ins(32'h3008));
    chk("c8_req",    {31'd0, imem_req}, 32'd1);
    chk("c8_addr",   imem_addr, 32'h300C);
    tick();                                     // 300C accepted -> WAIT

    // ---- redirect in WAIT, late response dropped ----
    drive(0, 1, 32'h4000, 1, 0, 0);
    chk("c9_req_redir", {31'd0, imem_req}, 32'd0);
    tick();                                     // -> DROP
    drive(0, 0, 0, 1, 0, 0);
    chk("c10_dvalid", {31'd0, D_valid}, 32'd0);
    chk("c10_req",    {31'd0, imem_req}, 32'd0);
    tick();
    drive(0, 0, 0, 1, 1, ins(32'h300C));        // stale response
    chk("c11_req", {31'd0, imem_req}, 32'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("c12_dvalid_drop", {31'd0, D_valid}, 32'd0);
    chk("c12_req",  {31'd0, imem_req}, 32'd1);
    chk("c12_addr", imem_addr, 32'h4000);
    tick();                                     // 4000 accepted
    drive(0, 0, 0, 1, 1, ins(32'h4000));
    tick();
    drive(1, 0, 0, 1, 0, 0);                    // stall with D live
    chk("c14_dvalid", {31'd0, D_valid}, 32'd1);
    chk("c14_dpc",    D_pc, 32'h4000);
    chk("c14_dinstr", D_instr, ins(32'h4000));
    chk("c14_addr",   imem_addr, 32'h4004);
    tick();                                     // 4004 accepted, D held

    // ---- redirect + rvalid same cycle under stall ----
    drive(1, 1, 32'h4000, 1, 1, ins(32'h4004));
    chk("c15_req", {31'd0, imem_req}, 32'd0);
    tick();
    // ---- imem_ready low for 4 cycles ----
    drive(0, 0, 0, 0, 0, 0);
    chk("c16_dvalid", {31'd0, D_valid}, 32'd0);
    chk("c16_dinstr", D_instr, 32'd0);
    chk("c16_req",    {31'd0, imem_req}, 32'd1);
    chk("c16_addr",   imem_addr, 32'h4000);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("nordy_addr", imem_addr, 32'h4000);
      chk("nordy_req",  {31'd0, imem_req}, 32'd1);
      tick();
    end

    // ---- wrap at top of address space ----
    drive(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    chk("c20_req_redir", {31'd0, imem_req}, 32'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("c21_addr", imem_addr, 32'hFFFF_FFFC);
    chk("c21_req",  {31'd0, imem_req}, 32'd1);
    tick();                                     // accepted, pc wraps to 0
    drive(0, 0, 0, 1, 1, ins(32'hFFFF_FFFC));
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("c23_dpc",   D_pc, 32'hFFFF_FFFC);
    chk("c23_dpc4",  D_pc4, 32'h0);
    chk("c23_addr",  imem_addr, 32'h0);
    chk("c23_dinstr", D_instr, ins(32'hFFFF_FFFC));
    tick();                                     // 0 accepted -> WAIT

    // ---- reset mid-WAIT, stray response right after ----
    resetn = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    tick();
    resetn = 1'b1;
    drive(0, 0, 0, 0, 1, ins(32'h0));           // stray beat in FETCH
    chk("pr_dvalid", {31'd0, D_valid}, 32'd0);
    chk("pr_addr",   imem_addr, RPC);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pr_ignored_dv",  {31'd0, D_valid}, 32'd0);
    chk("pr_ignored_ins", D_instr, 32'd0);
    chk("pr_req",         {31'd0, imem_req}, 32'd1);
    chk("pr_addr2",       imem_addr, RPC);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    tick();                                     // 3000 accepted
    drive(0, 0, 0, 1, 1, ins(RPC));
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("pr_dpc",   D_pc, RPC);
    chk("pr_dv",    {31'd0, D_valid}, 32'd1);
    chk("pr_dinstr", D_instr, ins(RPC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
